lfsr_gen: RTL and testbench
===========================

Name: lfsr_gen

Overview:
Parametrised LFSR pseudo-random generator, the successor to the fixed 4-bit LFSR. Width, polynomial, reset seed and topology (Fibonacci or Galois) are parameters. Adds step enable, runtime seed load, all-zero lockup recovery, a serial output bit and period measurement. Used as the stimulus/scrambler source in datapath blocks and as a self-checking pattern generator in benches.

Parameters:
WIDTH, 8, state width in bits; legal range 3..32.
TAPS, 8'hB8, feedback polynomial mask, WIDTH bits; bit k set means x^(k+1) is in the polynomial; MSB must be set.
SEED, 1, state value after reset and after lockup recovery; must be nonzero.
GALOIS, 0, topology select: 0 = Fibonacci (shift left), 1 = Galois (shift right).

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
en_i  input  1  advance the LFSR by one step this cycle.
load_i  input  1  load seed_i into the state this cycle.
seed_i  input  WIDTH  runtime seed value.
lfsr_o  output  WIDTH  current state, registered.
bit_o  output  1  serial output bit: lfsr_o[WIDTH-1] in Fibonacci mode, lfsr_o[0] in Galois mode.
wrap_o  output  1  one-cycle pulse when the state returns to the start value.
period_o  output  WIDTH  number of steps in the last completed cycle, registered.
lockup_o  output  1  one-cycle pulse when all-zero recovery fires.

Behaviour:
- Reset (reset low, asynchronous): lfsr_o=SEED, start register=SEED, step counter=0, period_o=0, wrap_o=0, lockup_o=0.
- Priority each cycle: load_i > lockup recovery > en_i > hold.
- Load: state<=seed_i, start register<=seed_i, counter<=0, wrap_o=0. en_i is ignored in that cycle. Loading zero is accepted.
- Lockup: if en_i=1 and state==0, then state<=SEED, start register<=SEED, counter<=0, and lockup_o pulses on the next cycle. No shift occurs in that cycle.
- Fibonacci step: fb = XOR-reduce(state & TAPS); next = {state[WIDTH-2:0], fb}.
- Galois step: lsb = state[0]; next = (state >> 1) XOR (lsb ? TAPS : 0).
- Step count: counter increments on each step. If next == start register, then wrap_o=1 on the next cycle, period_o<=counter+1, and counter<=0.
- Counter saturates at all-ones and does not wrap. For a maximal polynomial the period is 2^WIDTH-1, which fits in WIDTH bits.
- Latency: one cycle from en_i to new lfsr_o. wrap_o and lockup_o are registered and align with the updated lfsr_o.
- en_i=0: state, counter and period_o hold; wrap_o and lockup_o are 0.
- Reset asserted mid-run: immediate return to reset values. No pulse is generated on release.

Decomposition:
- Shared package lfsr_pkg:
  - mode constants LFSR_FIB=0 and LFSR_GAL=1;
  - default maximal-length tap masks per width (4'hC, 5'h14, 8'hB8, 16'hB400, 32'h80200003).
- Sub-module lfsr_next (combinational next-state function for both topologies) is natural. It is reused by checkers.
- Top level holds the state, start register, counter and pulse registers.

Test Plan:
1. WIDTH=4, TAPS=4'hC, SEED=1, GALOIS=0: release reset, hold en_i=1. Expect lfsr_o = 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,1. wrap_o pulses with lfsr_o=1 and period_o=15.
2. Same configuration, GALOIS=1, en_i=1. Expect lfsr_o = 1,C,6,3,D,… and wrap_o after 15 steps with period_o=15. Check bit_o==lfsr_o[0] every cycle.
3. Pulse load_i with seed_i=4'h5 while en_i=1. Expect lfsr_o=5 next cycle and no shift in that cycle. The next wrap_o fires when lfsr_o returns to 5, with period_o=15.
4. Load seed_i=0, then en_i=1. Expect lfsr_o=SEED=1 and lockup_o high for exactly one cycle, with wrap_o=0.
5. Toggle en_i as 1,0,0,1 from seed 1 (Fibonacci). Expect lfsr_o = 2,2,2,4, with counter and period_o frozen while en_i=0.
6. Assert reset mid-sequence, asynchronously between clock edges. Expect lfsr_o=1, period_o=0 and no pulses immediately. Then repeat scenario 1 with WIDTH=8, TAPS=8'hB8 and expect period_o=255.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants for the lfsr_gen pseudo-random generator.
// Topology select values and default maximal-length tap masks.
package lfsr_pkg;

   localparam bit LFSR_FIB = 1'b0;
   localparam bit LFSR_GAL = 1'b1;

   localparam logic [3:0]  LFSR_TAPS_4  = 4'hC;
   localparam logic [4:0]  LFSR_TAPS_5  = 5'h14;
   localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
   localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
   localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR next-state function, Fibonacci or Galois.
// Shared between the generator and external checkers.
module lfsr_next
   import lfsr_pkg::*;
#(
   parameter int               WIDTH  = 8,
   parameter logic [WIDTH-1:0] TAPS   = WIDTH'(8'hB8),
   parameter bit               GALOIS = LFSR_FIB
) (
   input  logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] nxt
);

   generate
      if (GALOIS == LFSR_GAL) begin : g_gal
         always_comb begin
            nxt = cur >> 1;
            if (cur[0]) begin
               nxt = nxt ^ TAPS;
            end
         end
      end else begin : g_fib
         always_comb begin
            nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};
         end
      end
   endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator with seed load, lockup recovery
// and measurement of the period of the last completed cycle.
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int               WIDTH  = 8,
   parameter logic [WIDTH-1:0] TAPS   = WIDTH'(8'hB8),
   parameter logic [WIDTH-1:0] SEED   = WIDTH'(1),
   parameter bit               GALOIS = LFSR_FIB
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] seed_i,
   output logic [WIDTH-1:0] lfsr_o,
   output logic             bit_o,
   output logic             wrap_o,
   output logic [WIDTH-1:0] period_o,
   output logic             lockup_o
);

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] start_q;
   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] period_q;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] cnt_inc;
   logic             wrap_q;
   logic             lock_q;

   lfsr_next #(
      .WIDTH  (WIDTH),
      .TAPS   (TAPS),
      .GALOIS (GALOIS)
   ) u_next (
      .cur (state_q),
      .nxt (nxt)
   );

   // counter sticks at all-ones instead of wrapping
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= SEED;
         start_q  <= SEED;
         cnt_q    <= '0;
         period_q <= '0;
         wrap_q   <= 1'b0;
         lock_q   <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         lock_q <= 1'b0;
         if (load_i) begin
            state_q <= seed_i;
            start_q <= seed_i;
            cnt_q   <= '0;
         end else if (en_i && state_q == '0) begin
            state_q <= SEED;
            start_q <= SEED;
            cnt_q   <= '0;
            lock_q  <= 1'b1;
         end else if (en_i) begin
            state_q <= nxt;
            if (nxt == start_q) begin
               wrap_q   <= 1'b1;
               period_q <= cnt_inc;
               cnt_q    <= '0;
            end else begin
               cnt_q <= cnt_inc;
            end
         end
      end
   end

   assign lfsr_o   = state_q;
   assign bit_o    = (GALOIS == LFSR_GAL) ? state_q[0]
                                          : state_q[WIDTH-1];
   assign wrap_o   = wrap_q;
   assign period_o = period_q;
   assign lockup_o = lock_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: four configurations driven in
// lockstep, expected outputs from a behavioural model.
module tb_lfsr_gen;

   typedef struct packed {
      logic [3:0][7:0] lf;
      logic [3:0][7:0] pd;
      logic [3:0]      wr;
      logic [3:0]      lk;
   } obs_t;

   logic       clk;
   logic       reset;
   logic       en_i;
   logic       load_i;
   logic [7:0] seed;

   logic [3:0] l0, l1, p0, p1;
   logic [7:0] l2, l3, p2, p3;
   logic [3:0] bt, wr, lk;

   int checks = 0;
   int errors = 0;

   obs_t q[$];

   int cw[4] = '{4, 4, 8, 8};
   int ct[4] = '{12, 12, 184, 184};
   int cg[4] = '{0, 1, 0, 1};

   int ms[4], mst[4], mc[4], mp[4];
   bit mw[4], ml[4];

   lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .GALOIS(1'b0)) d0 (
      .clk(clk), .reset(reset), .en_i(en_i), .load_i(load_i),
      .seed_i(seed[3:0]), .lfsr_o(l0), .bit_o(bt[0]),
      .wrap_o(wr[0]), .period_o(p0), .lockup_o(lk[0]));

   lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .GALOIS(1'b1)) d1 (
      .clk(clk), .reset(reset), .en_i(en_i), .load_i(load_i),
      .seed_i(seed[3:0]), .lfsr_o(l1), .bit_o(bt[1]),
      .wrap_o(wr[1]), .period_o(p1), .lockup_o(lk[1]));

   lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h1), .GALOIS(1'b0)) d2 (
      .clk(clk), .reset(reset), .en_i(en_i), .load_i(load_i),
      .seed_i(seed), .lfsr_o(l2), .bit_o(bt[2]),
      .wrap_o(wr[2]), .period_o(p2), .lockup_o(lk[2]));

   lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h1), .GALOIS(1'b1)) d3 (
      .clk(clk), .reset(reset), .en_i(en_i), .load_i(load_i),
      .seed_i(seed), .lfsr_o(l3), .bit_o(bt[3]),
      .wrap_o(wr[3]), .period_o(p3), .lockup_o(lk[3]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int act_lf(int i);
      case (i)
         0: return int'(l0);
         1: return int'(l1);
         2: return int'(l2);
         default: return int'(l3);
      endcase
   endfunction

   function automatic int act_pd(int i);
      case (i)
         0: return int'(p0);
         1: return int'(p1);
         2: return int'(p2);
         default: return int'(p3);
      endcase
   endfunction

   task automatic chk(string name, int i, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s dut%0d got %0h want %0h", name, i, act, exp);
      end
   endtask

   function automatic int poly_step(int i, int s);
      int mask;
      mask = (1 << cw[i]) - 1;
      if (cg[i] == 0)
         return ((s << 1) | ($countones(s & ct[i]) % 2)) & mask;
      return (s >> 1) ^ (((s % 2) == 1) ? ct[i] : 0);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         ms[i] = 1; mst[i] = 1; mc[i] = 0;
         mp[i] = 0; mw[i] = 0; ml[i] = 0;
      end
   endfunction

   function automatic void model_step(int i, bit en, bit ld, int sd);
      int mask, nx, inc;
      mask = (1 << cw[i]) - 1;
      mw[i] = 0;
      ml[i] = 0;
      if (ld) begin
         ms[i] = sd & mask;
         mst[i] = ms[i];
         mc[i] = 0;
      end else if (en && ms[i] == 0) begin
         ms[i] = 1;
         mst[i] = 1;
         mc[i] = 0;
         ml[i] = 1;
      end else if (en) begin
         nx = poly_step(i, ms[i]);
         inc = (mc[i] == mask) ? mask : mc[i] + 1;
         ms[i] = nx;
         if (nx == mst[i]) begin
            mw[i] = 1;
            mp[i] = inc;
            mc[i] = 0;
         end else begin
            mc[i] = inc;
         end
      end
   endfunction

   function automatic obs_t snap();
      obs_t o;
      for (int i = 0; i < 4; i++) begin
         o.lf[i] = 8'(ms[i]);
         o.pd[i] = 8'(mp[i]);
         o.wr[i] = mw[i];
         o.lk[i] = ml[i];
      end
      return o;
   endfunction

   task automatic cyc(bit en, bit ld, int sd);
      @(negedge clk);
      reset = 1'b1;
      en_i = en;
      load_i = ld;
      seed = 8'(sd);
      for (int i = 0; i < 4; i++) model_step(i, en, ld, sd);
      q.push_back(snap());
   endtask

   task automatic hold_reset(int n);
      model_reset();
      repeat (n) begin
         @(negedge clk);
         en_i = 1'b0;
         load_i = 1'b0;
         q.push_back(snap());
      end
   endtask

   // scoreboard monitor: every clock presents a new output word
   always @(posedge clk) begin
      obs_t e;
      int w;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         for (int i = 0; i < 4; i++) begin
            w = int'(e.lf[i]);
            chk("lfsr", i, act_lf(i), w);
            chk("period", i, act_pd(i), int'(e.pd[i]));
            chk("wrap", i, int'(wr[i]), int'(e.wr[i]));
            chk("lockup", i, int'(lk[i]), int'(e.lk[i]));
            if (cg[i] == 1)
               chk("bit", i, int'(bt[i]), w % 2);
            else
               chk("bit", i, int'(bt[i]), (w >> (cw[i] - 1)) % 2);
         end
      end
   end

   initial begin
      int k;
      reset = 1'b0;
      en_i = 1'b0;
      load_i = 1'b0;
      seed = 8'h0;
      hold_reset(2);

      repeat (15) cyc(1, 0, 0);
      @(posedge clk); #2;
      chk("fib4_period15", 0, int'(p0), 15);
      chk("fib4_wrap_at_1", 0, int'(l0), 1);
      chk("gal4_period15", 1, int'(p1), 15);
      repeat (240) cyc(1, 0, 0);
      @(posedge clk); #2;
      chk("fib8_period255", 2, int'(p2), 255);
      chk("gal8_period255", 3, int'(p3), 255);

      cyc(0, 1, 1);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      cyc(1, 0, 0);
      @(posedge clk); #2;
      chk("toggle_en", 0, int'(l0), 4);

      cyc(1, 1, 5);
      @(posedge clk); #2;
      chk("load_no_shift", 0, int'(l0), 5);
      repeat (15) cyc(1, 0, 0);
      @(posedge clk); #2;
      chk("reload_wrap", 0, int'(wr[0]), 1);
      chk("reload_lfsr", 0, int'(l0), 5);

      cyc(0, 1, 0);
      cyc(1, 0, 0);
      @(posedge clk); #2;
      chk("lockup_pulse", 0, int'(lk[0]), 1);
      chk("lockup_seed", 0, int'(l0), 1);
      cyc(1, 0, 0);
      repeat (7) cyc(1, 0, 0);

      // asynchronous reset between edges
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("async_rst_lfsr", i, act_lf(i), 1);
         chk("async_rst_period", i, act_pd(i), 0);
         chk("async_rst_pulse", i, int'(wr[i]) + int'(lk[i]), 0);
      end
      hold_reset(2);

      for (int n = 0; n < 700; n++) begin
         k = (($urandom % 4) == 0) ? 0 : int'($urandom % 256);
         cyc(($urandom % 4) != 0, ($urandom % 24) == 0, k);
      end
      cyc(0, 0, 0);

      k = 0;
      while (q.size() > 0 && k < 5) begin
         @(posedge clk); #2;
         k++;
      end
      chk("queue_drained", 0, q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
